// File: rtl/alu_pkg.sv
// Shared definitions for the 32-bit ALU slice sequencer.
//   - Opcode encodings seen on in_op and driven onto alu_op.
//   - Sequencer state encoding.
//   - Small helpers that classify opcodes.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // AND/OR have no carry chain and report no carry or overflow.
  function automatic logic is_logic_op(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR);
  endfunction

  // SLT is run through the slice as a subtraction; the less-than bit is
  // derived here from the high pass, so the slice's own less path is unused.
  function automatic logic [2:0] slice_op(input logic [2:0] op);
    return (op == OP_SLT) ? OP_SUB : op;
  endfunction

endpackage

// File: rtl/alu32_slice_sequencer.sv
// Sequences one DATA_W-bit ALU operation as two passes through an external
// SLICE_W-bit ALU slice: low half first, then high half with the carry of the
// low pass chained in. SLT is computed as a subtraction and fixed up on the
// high-pass result (set ^ overflow).
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready             request handshake (ready only when idle)
//   in_op, in_a, in_b             opcode and operands
//   out_valid/out_ready           result handshake; result held until taken
//   out_result, out_cout,
//   out_overflow, out_zero,
//   out_err                       result and status of the finished operation
//   alu_a, alu_b, alu_op,
//   alu_cin, alu_less             driven to the slice (0 when not in a pass)
//   alu_result, alu_cout,
//   alu_set, alu_zero,
//   alu_overflow                  returned by the slice
module alu32_slice_sequencer
  import alu_pkg::*;
#(
  parameter int SLICE_W = 16,
  parameter int DATA_W  = 32  // must be 2*SLICE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [DATA_W-1:0]  in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic               out_cout,
  output logic               out_overflow,
  output logic               out_zero,
  output logic               out_err,
  output logic [SLICE_W-1:0] alu_a,
  output logic [SLICE_W-1:0] alu_b,
  output logic [2:0]         alu_op,
  output logic               alu_cin,
  output logic               alu_less,
  input  logic [SLICE_W-1:0] alu_result,
  input  logic               alu_cout,
  input  logic               alu_set,
  input  logic               alu_zero,
  input  logic               alu_overflow
);

  state_t              state, state_nxt;
  logic [2:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [SLICE_W-1:0]  res_lo_q;
  logic                carry_q;
  logic                zero_lo_q;
  logic                slt_bit;

  assign slt_bit = alu_set ^ alu_overflow;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (in_valid) state_nxt = is_legal_op(in_op) ? ST_LO : ST_DONE;
      ST_LO:   state_nxt = ST_HI;
      ST_HI:   state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: handshakes and slice drive, decoded from state and the
  // latched request.
  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    alu_cin   = 1'b0;
    alu_less  = 1'b0;
    unique case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_LO: begin
        alu_a   = a_q[SLICE_W-1:0];
        alu_b   = b_q[SLICE_W-1:0];
        alu_op  = slice_op(op_q);
        alu_cin = (op_q == OP_SUB) || (op_q == OP_SLT);
      end
      ST_HI: begin
        alu_a   = a_q[DATA_W-1:SLICE_W];
        alu_b   = b_q[DATA_W-1:SLICE_W];
        alu_op  = slice_op(op_q);
        alu_cin = is_logic_op(op_q) ? 1'b0 : carry_q;
      end
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Request latch, low-pass capture and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_lo_q     <= '0;
      carry_q      <= 1'b0;
      zero_lo_q    <= 1'b0;
      out_result   <= '0;
      out_cout     <= 1'b0;
      out_overflow <= 1'b0;
      out_zero     <= 1'b0;
      out_err      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q    <= in_op;
            a_q     <= in_a;
            b_q     <= in_b;
            out_err <= !is_legal_op(in_op);
            // Illegal opcodes skip both passes and report a clean zero.
            if (!is_legal_op(in_op)) begin
              out_result   <= '0;
              out_cout     <= 1'b0;
              out_overflow <= 1'b0;
              out_zero     <= 1'b1;
            end
          end
        end
        ST_LO: begin
          res_lo_q  <= alu_result;
          carry_q   <= alu_cout;
          zero_lo_q <= alu_zero;
        end
        ST_HI: begin
          out_cout     <= is_logic_op(op_q) ? 1'b0 : alu_cout;
          out_overflow <= is_logic_op(op_q) ? 1'b0 : alu_overflow;
          if (op_q == OP_SLT) begin
            out_result <= {{(DATA_W-1){1'b0}}, slt_bit};
            out_zero   <= !slt_bit;
          end else begin
            out_result <= {alu_result, res_lo_q};
            out_zero   <= zero_lo_q & alu_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu32_slice_sequencer.sv
// Self-checking bench for alu32_slice_sequencer. Contains a behavioural
// 16-bit slice wired to the alu_* ports and a 32-bit reference model that
// computes results directly from the operation definitions.
module tb_alu32_slice_sequencer;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_cout, out_overflow, out_zero, out_err;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_cin, alu_less, alu_cout, alu_set, alu_zero, alu_overflow;

  int total = 0;
  int bad   = 0;

  alu32_slice_sequencer #(.SLICE_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_cout(out_cout), .out_overflow(out_overflow), .out_zero(out_zero),
    .out_err(out_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_less(alu_less), .alu_result(alu_result), .alu_cout(alu_cout),
    .alu_set(alu_set), .alu_zero(alu_zero), .alu_overflow(alu_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 16-bit slice: b optionally inverted by op[2], adder with cin.
  logic [16:0] s_sum;
  logic [15:0] s_bb;
  always_comb begin
    s_bb         = alu_op[2] ? ~alu_b : alu_b;
    s_sum        = {1'b0, alu_a} + {1'b0, s_bb} + {16'b0, alu_cin};
    alu_result   = '0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    alu_set      = s_sum[15];
    case (alu_op)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010, 3'b110, 3'b111: begin
        alu_result   = (alu_op == 3'b111) ? {15'b0, alu_less} : s_sum[15:0];
        alu_cout     = s_sum[16];
        alu_overflow = (alu_a[15] == s_bb[15]) && (s_sum[15] != alu_a[15]);
      end
      default: ;
    endcase
    alu_zero = (alu_result == 16'h0);
  end

  typedef struct {
    logic [31:0] res;
    logic        cout, ovf, zero, err;
  } ref_t;

  // Reference model straight from the operation definitions on 32-bit values.
  function automatic ref_t ref_op(input logic [2:0] op, input logic [31:0] a, b);
    ref_t   r;
    logic [32:0] t;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '{32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    case (op)
      3'b000: r.res = a & b;
      3'b001: r.res = a | b;
      3'b010: begin
        t = {1'b0, a} + {1'b0, b};
        s = sa + sb;
        r.res = t[31:0]; r.cout = t[32];
        r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b110, 3'b111: begin
        t = {1'b0, a} + {1'b0, ~b} + 33'd1;
        s = sa - sb;
        r.cout = t[32];
        r.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        r.res  = (op == 3'b111) ? {31'b0, (sa < sb)} : t[31:0];
      end
      default: r.err = 1'b1;
    endcase
    r.zero = (r.res == 32'h0);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slice drive observed during the two passes of the last issued operation.
  logic [15:0] lo_a, hi_a, lo_b, hi_b;
  logic [2:0]  lo_op;
  logic        lo_cin, hi_cin;
  int          lat;

  // Present one request in IDLE and wait (bounded) for out_valid.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("in_ready before accept", in_ready, 1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    lo_a = alu_a; lo_b = alu_b; lo_op = alu_op; lo_cin = alu_cin;
    hi_a = 'x; hi_b = 'x; hi_cin = 1'bx;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin hi_a = alu_a; hi_b = alu_b; hi_cin = alu_cin; end
    end
    if (!out_valid) check("out_valid timeout", out_valid, 1);
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready after release", in_ready, 1);
    check("out_valid after release", out_valid, 0);
  endtask

  task automatic check_outputs(input string tag, input ref_t e);
    check({tag, " result"},   out_result,   e.res);
    check({tag, " cout"},     out_cout,     e.cout);
    check({tag, " overflow"}, out_overflow, e.ovf);
    check({tag, " zero"},     out_zero,     e.zero);
    check({tag, " err"},      out_err,      e.err);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, res;
    logic        cout, ovf, zero, err;
  } vec_t;

  vec_t vecs [12];

  initial begin
    ref_t        e;
    logic [31:0] held;
    logic [31:0] pick [6];

    vecs[0]  = '{"add carry lo->hi", 3'b010, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"sub overflow",     3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{"sub equal",        3'b110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{"slt neg<pos",      3'b111, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"slt ovf case",     3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{"and",              3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"or",               3'b001, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"illegal 011",      3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{"add wrap",         3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{"add overflow",     3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{"illegal 100",      3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{"and zero",         3'b000, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("reset in_ready",   in_ready,   1);
    check("reset out_valid",  out_valid,  0);
    check("reset out_result", out_result, 0);
    check("reset out_zero",   out_zero,   0);
    check("reset out_err",    out_err,    0);
    check("reset alu_a",      alu_a,      0);
    check("reset alu_op",     alu_op,     0);
    check("reset alu_cin",    alu_cin,    0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset in_ready",  in_ready,  1);
    check("post-reset out_valid", out_valid, 0);

    // Directed vector table.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check({vecs[i].name, " latency"}, lat, vecs[i].err ? 1 : 3);
      check_outputs(vecs[i].name, '{vecs[i].res, vecs[i].cout, vecs[i].ovf, vecs[i].zero, vecs[i].err});
      if (i == 0) begin
        check("add lo alu_a",   lo_a,   16'hFFFF);
        check("add lo alu_b",   lo_b,   16'h0001);
        check("add hi alu_a",   hi_a,   16'h0000);
        check("add lo alu_cin", lo_cin, 0);
        check("add hi alu_cin", hi_cin, 1);
      end
      if (i == 1) check("sub lo alu_cin", lo_cin, 1);
      if (i == 3) check("slt lo alu_op", lo_op, 3'b110);
      if (i == 5) check("and hi alu_b", hi_b, 16'h0FF0);
      if (i == 6) check("or hi alu_cin", hi_cin, 0);
      check("alu_less", alu_less, 0);
      release_out();
    end

    // Back-pressure: result held for 5 cycles, then no accept in DONE.
    issue(3'b010, 32'h1234_5678, 32'h1111_1111);
    held = out_result;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold out_valid", out_valid, 1);
      check("hold out_result", out_result, held);
      check("hold in_ready", in_ready, 0);
    end
    check("hold result value", held, 32'h2345_6789);
    // New request appears together with out_ready while still in DONE.
    in_valid = 1'b1; in_op = 3'b001; in_a = 32'h0000_00F0; in_b = 32'h0000_000F;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("no accept in DONE: in_ready", in_ready, 1);
    check("no accept in DONE: out_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin @(negedge clk); lat++; end
    check("late accept latency", lat, 3);
    check("late accept result", out_result, 32'h0000_00FF);
    release_out();

    // Reset asserted during the high pass.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'b010; in_a = 32'h0000_FFFF; in_b = 32'h0000_FFFF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-op reset out_valid", out_valid, 0);
    check("mid-op reset in_ready", in_ready, 1);
    check("mid-op reset alu_a", alu_a, 0);
    check("mid-op reset out_result", out_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("after reset out_valid", out_valid, 0);
      check("after reset in_ready", in_ready, 1);
    end
    issue(3'b110, 32'h0001_0000, 32'h0000_0001);
    check_outputs("after reset sub", ref_op(3'b110, 32'h0001_0000, 32'h0000_0001));
    release_out();

    // Randomized operations against the reference model.
    pick[0] = 32'h0000_0000; pick[1] = 32'hFFFF_FFFF; pick[2] = 32'h8000_0000;
    pick[3] = 32'h7FFF_FFFF; pick[4] = 32'h0000_FFFF; pick[5] = 32'hFFFF_0000;
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      e = ref_op(op, a, b);
      issue(op, a, b);
      check("rand latency", lat, e.err ? 1 : 3);
      check_outputs("rand", e);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      check("rand held", out_valid, 1);
      release_out();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
